// File: rtl/kf_predict_unit.sv
// Kalman time-update stage: x' = F*x and P' = F*P*F^T + Q for a 6-state constant-velocity model.
// One state element per cycle, then one covariance element per cycle. Results saturate to signed Q8.8.
module kf_predict_unit #(
  parameter logic signed [15:0] Q_POS = 16'sh0010,
  parameter logic signed [15:0] Q_VEL = 16'sh0020
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  dt,
  input  logic [95:0]  x_in,
  input  logic [575:0] p_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  x_out,
  output logic [575:0] p_out
);

  typedef enum logic [2:0] {IDLE, PREP, STATE, COV, DONE} state_t;
  state_t state, state_n;

  logic [5:0]         e;
  logic signed [15:0] dt_r;
  logic signed [23:0] dt2;
  logic signed [15:0] x_r [6];
  logic signed [15:0] p_r [36];

  logic [5:0]         row, col;
  logic [2:0]         k;
  logic signed [15:0] base, q, op_b;
  logic signed [16:0] op_a;
  logic signed [31:0] dt_sq;
  logic signed [32:0] mul_a;
  logic signed [39:0] mul_b;
  logic signed [24:0] term_a;
  logic signed [31:0] term_b;
  logic signed [33:0] acc;
  logic [15:0]        sat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = PREP;
      PREP:    state_n = STATE;
      STATE:   if (e == 6'd2) state_n = COV;
      COV:     if (e == 6'd35) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Shared datapath: STATE reuses the dt multiplier for dt*v; COV picks the block-dependent operands.
  always_comb begin
    row  = e / 6'd6;
    col  = e % 6'd6;
    k    = e[2:0];
    base = '0;
    op_a = '0;
    op_b = '0;
    q    = '0;
    if (state == STATE) begin
      base = x_r[k];
      op_a = 17'(x_r[k + 3'd3]);
    end else if (state == COV) begin
      base = p_r[e];
      if (row < 6'd3 && col < 6'd3) begin
        op_a = 17'(p_r[e + 6'd3]) + 17'(p_r[e + 6'd18]);
        op_b = p_r[e + 6'd21];
      end else if (row < 6'd3) begin
        op_a = 17'(p_r[e + 6'd18]);
      end else if (col < 6'd3) begin
        op_a = 17'(p_r[e + 6'd3]);
      end
      if (row == col) q = (row < 6'd3) ? Q_POS : Q_VEL;
    end
    dt_sq  = 32'(dt_r) * 32'(dt_r);
    mul_a  = 33'(dt_r) * 33'(op_a);
    mul_b  = 40'(dt2) * 40'(op_b);
    term_a = 25'(mul_a >>> 8);
    term_b = 32'(mul_b >>> 8);
    acc    = 34'(base) + 34'(term_a) + 34'(term_b) + 34'(q);
    if (acc > 34'sd32767)       sat = 16'h7fff;
    else if (acc < -34'sd32768) sat = 16'h8000;
    else                        sat = acc[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e     <= '0;
      dt_r  <= '0;
      dt2   <= '0;
      x_out <= '0;
      p_out <= '0;
      for (int n = 0; n < 6; n++)  x_r[n] <= '0;
      for (int n = 0; n < 36; n++) p_r[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          e <= '0;
          if (in_valid) begin
            dt_r <= dt;
            for (int n = 0; n < 6; n++)  x_r[n] <= x_in[16*n +: 16];
            for (int n = 0; n < 36; n++) p_r[n] <= p_in[16*n +: 16];
          end
        end
        PREP: dt2 <= 24'(dt_sq >>> 8);
        STATE: begin
          x_out[{k, 4'b0} +: 16]         <= sat;
          x_out[{k + 3'd3, 4'b0} +: 16]  <= x_r[k + 3'd3];
          e <= (e == 6'd2) ? 6'd0 : e + 6'd1;
        end
        COV: begin
          p_out[{e, 4'b0} +: 16] <= sat;
          e <= (e == 6'd35) ? 6'd0 : e + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_predict_unit.sv
// Self-checking bench for kf_predict_unit: directed cases plus randomized transactions
// checked against a longint reference of the prediction equations.
module tb_kf_predict_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0]  dt;
  logic [95:0]  x_in, x_out;
  logic [575:0] p_in, p_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [95:0]  exp_x;
  logic [575:0] exp_p;

  always @(posedge clk) cyc <= cyc + 1;

  kf_predict_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .dt(dt),
    .x_in(x_in), .p_in(p_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .p_out(p_out)
  );

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint el(input logic [575:0] v, input int idx);
    return longint'($signed(v[16*idx +: 16]));
  endfunction

  function automatic logic [15:0] sat16(input longint a);
    if (a > 32767)  return 16'h7fff;
    if (a < -32768) return 16'h8000;
    return a[15:0];
  endfunction

  // Reference: each predicted element from the block-matrix rules, full precision then saturate.
  task automatic run_model(input logic [15:0] d, input logic [95:0] xv, input logic [575:0] pv);
    longint dl, d2, a;
    logic [575:0] xw;
    dl = longint'($signed(d));
    d2 = (dl * dl) >>> 8;
    xw = {480'b0, xv};
    for (int n = 0; n < 3; n++) begin
      exp_x[16*n +: 16]     = sat16(el(xw, n) + ((dl * el(xw, n + 3)) >>> 8));
      exp_x[16*(n+3) +: 16] = xv[16*(n+3) +: 16];
    end
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        a = el(pv, 6*i + j);
        if (i < 3 && j < 3)
          a = a + ((dl * (el(pv, 6*i + j + 3) + el(pv, 6*(i+3) + j))) >>> 8)
                + ((d2 * el(pv, 6*(i+3) + j + 3)) >>> 8);
        else if (i < 3)
          a = a + ((dl * el(pv, 6*(i+3) + j)) >>> 8);
        else if (j < 3)
          a = a + ((dl * el(pv, 6*i + j + 3)) >>> 8);
        if (i == j) a = a + ((i < 3) ? 16 : 32);
        exp_p[16*(6*i + j) +: 16] = sat16(a);
      end
    end
  endtask

  task automatic gen(input bit big, output logic [95:0] xv, output logic [575:0] pv);
    for (int n = 0; n < 6; n++)
      xv[16*n +: 16] = big ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
    for (int n = 0; n < 36; n++)
      pv[16*n +: 16] = big ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
  endtask

  // Called at a negedge; drives one accepted transaction and records its cycle.
  task automatic applyStimulus(input logic [15:0] d, input logic [95:0] xv, input logic [575:0] pv);
    int waitc = 0;
    run_model(d, xv, pv);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_ready", in_ready, 1'b1);
    dt = d;
    x_in = xv;
    p_in = pv;
    in_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_not_ready", in_ready, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input int hold, input bit early);
    int waitc = 0;
    if (early) out_ready = 1'b1;
    while (!out_valid && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_latency"}, cyc - acc_cyc, 41);
    check({tag, "_x"}, x_out, exp_x);
    check({tag, "_p"}, p_out, exp_p);
    for (int c = 0; c < hold; c++) begin
      if (c == hold / 2) begin
        in_valid = 1'b1;
        dt = 16'($urandom);
        x_in = {3{32'($urandom)}};
        p_in = {18{32'($urandom)}};
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      check({tag, "_hold_x"}, x_out, exp_x);
      check({tag, "_hold_p"}, p_out, exp_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 1'b0);
    check({tag, "_reready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [95:0]  xv;
    logic [575:0] pv;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dt = '0;
    x_in = '0;
    p_in = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_x_out", x_out, 96'b0);
      check("rst_p_out", p_out, 576'b0);
      check("rst_in_ready", in_ready, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);

    // dt = 0: state passes through, covariance only gains Q on the diagonal
    gen(1'b1, xv, pv);
    applyStimulus(16'h0000, xv, pv);
    checkOutput("dt0", 0, 1'b0);
    check("dt0_x_identity", x_out, xv);

    // Unit timestep with identity covariance
    xv = {16'h0100, 16'hffc0, 16'h0080, 16'h0300, 16'h0200, 16'h0100};
    pv = '0;
    for (int n = 0; n < 6; n++) pv[16*(7*n) +: 16] = 16'h0100;
    applyStimulus(16'h0100, xv, pv);
    checkOutput("unit", 0, 1'b0);
    check("unit_px", x_out[15:0], 16'h0180);
    check("unit_py", x_out[31:16], 16'h01c0);
    check("unit_pz", x_out[47:32], 16'h0400);
    check("unit_p00", p_out[16*0 +: 16], 16'h0210);
    check("unit_p03", p_out[16*3 +: 16], 16'h0100);
    check("unit_p30", p_out[16*18 +: 16], 16'h0100);
    check("unit_p33", p_out[16*21 +: 16], 16'h0120);
    check("unit_p12", p_out[16*8 +: 16], 16'h0000);

    // Saturation, positive then negative
    gen(1'b0, xv, pv);
    xv[15:0] = 16'h7f00;
    xv[63:48] = 16'h7f00;
    applyStimulus(16'h0100, xv, pv);
    checkOutput("sat_pos", 0, 1'b0);
    check("sat_pos_px", x_out[15:0], 16'h7fff);
    xv[15:0] = 16'h8100;
    xv[63:48] = 16'h8100;
    applyStimulus(16'h0100, xv, pv);
    checkOutput("sat_neg", 0, 1'b0);
    check("sat_neg_px", x_out[15:0], 16'h8000);

    // Randomized transactions, including backpressure and same-cycle consume
    for (int t = 0; t < 8; t++) begin
      gen(t[0], xv, pv);
      applyStimulus(t[1] ? 16'($urandom_range(0, 32767)) : 16'($urandom_range(0, 1024)), xv, pv);
      checkOutput("rand", (t == 2) ? 10 : 0, t == 5);
    end

    // Reset in the middle of the covariance sweep
    gen(1'b0, xv, pv);
    applyStimulus(16'h0180, xv, pv);
    while (cyc < acc_cyc + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_x_out", x_out, 96'b0);
    check("midrst_p_out", p_out, 576'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    gen(1'b0, xv, pv);
    applyStimulus(16'($urandom_range(0, 1024)), xv, pv);
    checkOutput("after_rst", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
